// File: rtl/rv_sender.sv
// Transmit-side valid/ready controller: DEPTH-entry FIFO feeding an external valid register.
// Define RV_SENDER_STATS_EN to add the saturating stall_cnt output.
module rv_sender #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     valid_q,
    output logic                     valid_reg,
    output logic                     valid_en,
    input  logic                     ready,
    output logic [WIDTH-1:0]         out_data
`ifdef RV_SENDER_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] LOADED  = 2'd1;
    localparam logic [1:0] SENDING = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             acc;
    logic             pop;
    logic [CW-1:0]    count_next;

    // full is registered state, so a push while full is dropped even if a pop frees a slot
    assign full       = (count == CW'(DEPTH));
    assign acc        = push && !full;
    assign pop        = valid_q && ready;
    assign count_next = count + CW'(acc) - CW'(pop);

    assign valid_reg  = rst && (count_next != '0);
    assign valid_en   = !rst || (valid_reg != valid_q);
    assign out_data   = mem[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (acc) state_next = LOADED;
            // a word popped on its first visible cycle leaves nothing to send
            LOADED:  if (count_next == '0) state_next = EMPTY;
                     else if (valid_q)     state_next = SENDING;
            SENDING: if (count_next == '0) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            state    <= EMPTY;
        end else begin
            count <= count_next;
            state <= state_next;
            if (acc)         wr_ptr   <= wr_ptr + PW'(1);
            if (pop)         rd_ptr   <= rd_ptr + PW'(1);
            if (push && full) overflow <= 1'b1;
        end
    end

    // storage is cleared so out_data reads zero after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

`ifdef RV_SENDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if (valid_q && !ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(state == EMPTY && valid_q))
                else $error("rv_sender: valid_q high while EMPTY");
            assert (!(state == SENDING && !valid_q))
                else $error("rv_sender: valid_q low while SENDING");
        end
    end
`endif
endmodule

// File: tb/tb_rv_sender.sv
// Randomized bench for rv_sender: queue-based reference model plus directed scenarios.
module tb_rv_sender;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic [WIDTH-1:0]  push_data;
    logic              full;
    logic [2:0]        count;
    logic              overflow;
    logic              valid_q;
    logic              valid_reg;
    logic              valid_en;
    logic              ready;
    logic [WIDTH-1:0]  out_data;
`ifdef RV_SENDER_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    rv_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full), .count(count), .overflow(overflow),
        .valid_q(valid_q), .valid_reg(valid_reg), .valid_en(valid_en),
        .ready(ready), .out_data(out_data)
`ifdef RV_SENDER_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // external 1-bit valid register
    always_ff @(posedge clk) if (valid_en) valid_q <= valid_reg;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue, delivered words logged in order
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_deliv[$];
    logic [WIDTH-1:0] d_deliv[$];
    bit               m_ovf = 1'b0;
    int               m_stall = 0;
    bit               m_valid;
    bit               m_full;

    always @(posedge clk) begin
        if (rst === 1'b1 && valid_q === 1'b1 && ready === 1'b1) d_deliv.push_back(out_data);
        if (rst !== 1'b1) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_stall = 0;
        end else begin
            m_valid = (m_q.size() != 0);
            m_full  = (m_q.size() == DEPTH);
            if (m_valid && !ready && m_stall != 16'hFFFF) m_stall++;
            if (m_valid && ready) m_deliv.push_back(m_q.pop_front());
            if (push) begin
                if (m_full) m_ovf = 1'b1;
                else        m_q.push_back(push_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_q", 64'(valid_q), 64'(m_q.size() != 0));
            check("count", 64'(count), 64'(m_q.size()));
            check("full", 64'(full), 64'(m_q.size() == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
            if (m_q.size() != 0) check("out_data", 64'(out_data), 64'(m_q[0]));
`ifdef RV_SENDER_STATS_EN
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
    end

    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic r);
        push = p;
        push_data = d;
        ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; push_data = '0; ready = 1'b0;

        // 1: reset
        step(0, 0, 0);
        step(0, 0, 0);
        check("rst_valid_q", 64'(valid_q), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // 2: single word, latency 1
        step(1, 32'hA5A5_0001, 1);
        check("t2_valid_q", 64'(valid_q), 64'd1);
        check("t2_out_data", 64'(out_data), 64'hA5A5_0001);
        step(0, 0, 1);
        check("t2_count", 64'(count), 64'd0);
        check("t2_valid_q_low", 64'(valid_q), 64'd0);

        // 3: stall then drain in order
        for (int i = 0; i < 3; i++) step(1, 32'h1111_0000 + i, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            check("t3_hold_data", 64'(out_data), 64'h1111_0000);
            check("t3_hold_valid", 64'(valid_q), 64'd1);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("t3_count", 64'(count), 64'd0);
        check("t3_ndeliv", 64'(d_deliv.size()), 64'd4);
        for (int i = 0; i < 3; i++)
            if (d_deliv.size() == 4) check("t3_order", 64'(d_deliv[i+1]), 64'(32'h1111_0000 + i));

        // 4: overflow
        for (int i = 0; i < 5; i++) step(1, 32'h4444_0000 + i, 0);
        check("t4_full", 64'(full), 64'd1);
        check("t4_count", 64'(count), 64'd4);
        check("t4_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        check("t4_ndeliv", 64'(d_deliv.size()), 64'd8);
        if (d_deliv.size() == 8) check("t4_last", 64'(d_deliv[7]), 64'h4444_0003);
        check("t4_sticky", 64'(overflow), 64'd1);

        // 5: simultaneous push and pop
        step(1, 32'h5555_0000, 0);
        step(1, 32'h5555_0001, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 32'h5555_0002 + i, 1);
            check("t5_count", 64'(count), 64'd2);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        check("t5_ndeliv", 64'(d_deliv.size()), 64'd16);
        for (int i = 0; i < 8; i++)
            if (d_deliv.size() == 16) check("t5_order", 64'(d_deliv[8+i]), 64'(32'h5555_0000 + i));

        // 6: reset mid-transfer
        for (int i = 0; i < 3; i++) step(1, 32'h6666_0000 + i, 0);
        rst = 1'b0;
        step(0, 0, 0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid_q", 64'(valid_q), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
`ifdef RV_SENDER_STATS_EN
        check("t6_stall", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b1;
        step(0, 0, 1);
        check("t6_ndeliv", 64'(d_deliv.size()), 64'd16);

        // random phase
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1));
        end
        rst = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1);

        check("deliv_size", 64'(d_deliv.size()), 64'(m_deliv.size()));
        if (d_deliv.size() == m_deliv.size())
            for (int i = 0; i < d_deliv.size(); i++)
                if (d_deliv[i] !== m_deliv[i]) check("deliv_word", 64'(d_deliv[i]), 64'(m_deliv[i]));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
